led_chaser_pio_in: RTL and testbench



---
 rtl/led_chaser_pio_in_pkg.sv | 9 +
 rtl/led_chaser_pio_in_sync.sv | 50 +++++
 rtl/led_chaser_pio_in.sv | 62 ++++++
 tb/tb_led_chaser_pio_in.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/led_chaser_pio_in_pkg.sv
// led_chaser_pio_pkg: register map, edge-type encoding and bus width for the input PIO
package led_chaser_pio_pkg;
  localparam int RD_W = 32;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;
  typedef enum int {EDGE_RISE = 0, EDGE_FALL = 1, EDGE_ANY = 2} edge_t;
endpackage

// File: rtl/led_chaser_pio_in_sync.sv
// pio_in_sync: input synchronizer, optional debounce (LED_CHASER_PIO_IN_DEBOUNCE_EN) and edge detect
module pio_in_sync
  import led_chaser_pio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] detect
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
`ifdef LED_CHASER_PIO_IN_DEBOUNCE_EN
  logic [WIDTH-1:0] deb_q;
  logic [WIDTH-1:0][15:0] cnt_q;
  // a bit only follows the synchronizer after DEBOUNCE_CYCLES unbroken mismatching cycles
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      deb_q <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (sync_q[SYNC_STAGES-1][i] != deb_q[i]) begin
          if (cnt_q[i] == 16'(DEBOUNCE_CYCLES - 1)) begin
            deb_q[i] <= sync_q[SYNC_STAGES-1][i];
            cnt_q[i] <= '0;
          end else cnt_q[i] <= cnt_q[i] + 16'd1;
        end else cnt_q[i] <= '0;
    end
  assign data_in = deb_q;
`else
  localparam int unused_debounce = DEBOUNCE_CYCLES;
  assign data_in = sync_q[SYNC_STAGES-1];
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) prev_q <= '0;
    else prev_q <= data_in;
  always_comb
    detect = EDGE_TYPE == int'(EDGE_FALL) ? ~data_in & prev_q :
             EDGE_TYPE == int'(EDGE_ANY)  ? data_in ^ prev_q  :
                                            data_in & ~prev_q;
endmodule

// File: rtl/led_chaser_pio_in.sv
// led_chaser_pio_in: Avalon-MM input PIO with sticky edge capture and maskable irq
// optional per-bit debounce when LED_CHASER_PIO_IN_DEBOUNCE_EN is defined
module led_chaser_pio_in
  import led_chaser_pio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam logic [2:0] SETTLE_N = 3'(SYNC_STAGES + 1);
  logic [WIDTH-1:0] data_in, detect, mask_q, edge_q, clr, set;
  logic [2:0] settle_q;
  logic wr;
  logic unused_wd;
  assign unused_wd = ^writedata;
  pio_in_sync #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE(EDGE_TYPE),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync (
    .clk(clk),
    .reset_n(reset_n),
    .in_port(in_port),
    .data_in(data_in),
    .detect(detect)
  );
  // hides the synchronizer filling up so inputs high at reset do not capture
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) settle_q <= '0;
    else if (settle_q != SETTLE_N) settle_q <= settle_q + 3'd1;
  always_comb begin
    wr  = chipselect & ~write_n;
    clr = wr && address == ADDR_EDGE ? writedata[WIDTH-1:0] : '0;
    set = settle_q == SETTLE_N ? detect : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mask_q <= '0;
      edge_q <= '0;
    end else begin
      if (wr && address == ADDR_MASK) mask_q <= writedata[WIDTH-1:0];
      edge_q <= (edge_q & ~clr) | set;
    end
  always_comb begin
    readdata = address == ADDR_DATA ? RD_W'(data_in) :
               address == ADDR_MASK ? RD_W'(mask_q)  :
               address == ADDR_EDGE ? RD_W'(edge_q)  : '0;
    irq = |(edge_q & mask_q);
  end
endmodule

// File: tb/tb_led_chaser_pio_in.sv
// tb_led_chaser_pio_in: rise/fall/any instances checked against a queue-based model plus literals
module tb_led_chaser_pio_in;
  localparam int W = 8;
  localparam int S = 2;
  logic clk = 0;
  logic reset_n = 0;
  logic [1:0] address = 0;
  logic chipselect = 0;
  logic write_n = 1;
  logic [31:0] writedata = 0;
  logic [W-1:0] in_port = 0;
  logic [2:0][31:0] rd;
  logic [2:0] irq;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  led_chaser_pio_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[0]), .irq(irq[0]));
  led_chaser_pio_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[1]), .irq(irq[1]));
  led_chaser_pio_in #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[2]), .irq(irq[2]));
  // model: the visible data is the in_port sample taken S edges ago
  logic [W-1:0] hist[$];
  int n;
  logic [W-1:0] m_mask;
  logic [W-1:0] m_cap [3];
  function automatic logic [W-1:0] h(int back);
    return hist.size() >= back ? hist[hist.size() - back] : '0;
  endfunction
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hist.delete();
      n = 0;
      m_mask = 0;
      for (int k = 0; k < 3; k++) m_cap[k] = 0;
    end else begin
      logic [W-1:0] dn, dp, clr, det;
      dn = h(S);
      dp = h(S + 1);
      clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      for (int k = 0; k < 3; k++) begin
        det = k == 0 ? dn & ~dp : k == 1 ? ~dn & dp : dn ^ dp;
        m_cap[k] = (m_cap[k] & ~clr) | (n >= S + 1 ? det : '0);
      end
      hist.push_back(in_port);
      if (hist.size() > S + 1) void'(hist.pop_front());
      if (n < 1000) n++;
    end
  function automatic logic [31:0] exp_rd(int k);
    return address == 2'd0 ? 32'(h(S)) : address == 2'd2 ? 32'(m_mask) :
           address == 2'd3 ? 32'(m_cap[k]) : 32'd0;
  endfunction
  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask
  always @(negedge clk)
    for (int k = 0; k < 3; k++) begin
      check($sformatf("model_rd%0d_a%0d", k, address), rd[k], exp_rd(k));
      check($sformatf("model_irq%0d", k), 32'(irq[k]), 32'(|(m_cap[k] & m_mask)));
    end
  task automatic cyc(int c);
    repeat (c) @(posedge clk);
    #1;
  endtask
  task automatic lit(string name, int k, logic [1:0] a, logic [31:0] exp);
    address = a;
    #1;
    check(name, rd[k], exp);
  endtask
  task automatic lit_irq(string name, int k, logic exp);
    #1;
    check(name, 32'(irq[k]), 32'(exp));
  endtask
  task automatic wr(logic [1:0] a, logic [31:0] d);
    address = a;
    chipselect = 1;
    write_n = 0;
    writedata = d;
    cyc(1);
    chipselect = 0;
    write_n = 1;
  endtask
  initial begin
    in_port = 8'hFF;
    cyc(3);
    reset_n = 1;
    cyc(10);
    lit("settle_cap_rise", 0, 2'd3, 0);
    lit("settle_cap_fall", 1, 2'd3, 0);
    lit("settle_cap_any", 2, 2'd3, 0);
    cyc(1);
    lit("settle_data", 0, 2'd0, 32'h0000_00FF);
    lit_irq("settle_irq", 0, 0);
    in_port = 8'h00;
    cyc(5);
    wr(2'd3, 32'hFF);
    wr(2'd2, 32'h01);
    in_port = 8'h01;
    cyc(1);
    lit("sync_not_yet", 0, 2'd0, 0);
    cyc(1);
    lit("sync_data", 0, 2'd0, 1);
    lit("cap_not_yet", 0, 2'd3, 0);
    cyc(1);
    lit("cap_rise", 0, 2'd3, 8'h01);
    lit_irq("irq_rise", 0, 1);
    wr(2'd3, 32'h01);
    lit("w1c", 0, 2'd3, 0);
    lit_irq("irq_cleared", 0, 0);
    wr(2'd2, 32'h00);
    in_port = 8'h09;
    cyc(1);
    in_port = 8'h01;
    cyc(6);
    lit("pulse_cap", 0, 2'd3, 8'h08);
    lit_irq("pulse_masked", 0, 0);
    lit("pulse_cap_fall", 1, 2'd3, 8'h08);
    wr(2'd2, 32'h08);
    lit_irq("unmask_irq", 0, 1);
    wr(2'd3, 32'hFF);
    in_port = 8'h05;
    cyc(2);
    wr(2'd3, 32'h04);
    lit("set_wins", 0, 2'd3, 8'h04);
    lit("set_wins_any", 2, 2'd3, 8'h04);
    wr(2'd3, 32'h02);
    lit("clr_idle_bit", 0, 2'd3, 8'h04);
    wr(2'd3, 32'hFF);
    in_port = 8'h85;
    cyc(4);
    lit("any_rise", 2, 2'd3, 8'h80);
    lit("rise_b7", 0, 2'd3, 8'h80);
    wr(2'd3, 32'h80);
    lit("any_clr", 2, 2'd3, 0);
    in_port = 8'h05;
    cyc(4);
    lit("any_fall", 2, 2'd3, 8'h80);
    lit("rise_no_fall", 0, 2'd3, 0);
    lit("fall_b7", 1, 2'd3, 8'h80);
    cyc(1);
    lit("rsvd_zero", 2, 2'd1, 0);
    wr(2'd0, 32'hFFFF_FFFF);
    lit("data_ro", 0, 2'd0, 8'h05);
    wr(2'd2, 32'hFF);
    lit_irq("pre_reset_irq", 2, 1);
    reset_n = 0;
    lit("reset_cap", 2, 2'd3, 0);
    lit_irq("reset_irq", 2, 0);
    lit("reset_mask", 2, 2'd2, 0);
    cyc(2);
    reset_n = 1;
    cyc(10);
    lit("resettle_data", 0, 2'd0, 8'h05);
    lit("resettle_cap", 2, 2'd3, 0);
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
